// File: rtl/alu_mdu_if.sv
// alu_mdu_if: request/response bundle for the alu_mdu block.
//   master : request side (drives in_valid, op, A, B, out_ready)
//   slave  : the alu_mdu itself (drives in_ready, out_valid, Result, flags)
interface alu_mdu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;
  logic             Carry;
  logic             OverFlow;
  logic             Zero;
  logic             Negative;

  modport master (
    output in_valid, op, A, B, out_ready,
    input  in_ready, out_valid, Result, Carry, OverFlow, Zero, Negative
  );

  modport slave (
    input  in_valid, op, A, B, out_ready,
    output in_ready, out_valid, Result, Carry, OverFlow, Zero, Negative
  );
endinterface

// File: rtl/alu_mdu.sv
// alu_mdu: single-cycle ALU plus iterative multiply/divide unit.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : alu_mdu_if.slave -- request (in_valid/in_ready, op, A, B) and
//         registered response (out_valid/out_ready, Result, Carry,
//         OverFlow, Zero, Negative)
//
// state | meaning
// IDLE  | waiting for a request, in_ready = 1
// BUSY  | multiply/divide iterating, one bit per cycle for WIDTH cycles
// DONE  | Result/flags valid, held until out_ready
module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic      clk,
  input logic      rst,
  alu_mdu_if.slave bus
);
  localparam int SH_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;

  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] mc, hi, lo, hi_n, lo_n;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] result_q;
  logic             carry_q, ovf_q, zero_q, neg_q;

  logic accept, is_mdu, signed_div, last_step;
  assign accept     = bus.in_valid && (state == IDLE);
  assign is_mdu     = bus.op[3] & (bus.op[2] | bus.op[1]);
  assign signed_div = (bus.op == 4'd12) || (bus.op == 4'd14);
  assign last_step  = (state == BUSY) && (cnt == CNT_W'(1));

  // ---------------- single-cycle ALU ----------------
  logic [WIDTH:0]   add_full;
  logic [WIDTH-1:0] sub_res, alu_res;
  logic             alu_c, alu_v;
  logic [SH_W-1:0]  shamt;

  assign add_full = {1'b0, bus.A} + {1'b0, bus.B};
  assign sub_res  = bus.A - bus.B;
  assign shamt    = bus.B[SH_W-1:0];

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.op)
      4'd0: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                  (add_full[WIDTH-1] != bus.A[WIDTH-1]);
      end
      4'd1: begin
        alu_res = sub_res;
        alu_c   = bus.A < bus.B;
        alu_v   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                  (sub_res[WIDTH-1] != bus.A[WIDTH-1]);
      end
      4'd2: alu_res = bus.A & bus.B;
      4'd3: alu_res = bus.A | bus.B;
      4'd4: alu_res = bus.A ^ bus.B;
      4'd5: alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
      4'd6: alu_res = {{(WIDTH-1){1'b0}}, bus.A < bus.B};
      4'd7: alu_res = bus.A << shamt;
      4'd8: alu_res = bus.A >> shamt;
      4'd9: alu_res = $signed(bus.A) >>> shamt;
      default: ;
    endcase
  end

  // ---------------- iterative multiply / divide ----------------
  // Operands enter as magnitudes; signs are re-applied on the last step.
  logic [WIDTH-1:0] mag_a, mag_b;
  assign mag_a = (signed_div && bus.A[WIDTH-1]) ? -bus.A : bus.A;
  assign mag_b = (signed_div && bus.B[WIDTH-1]) ? -bus.B : bus.B;

  // hi:lo is the product (multiply) or remainder:quotient (divide).
  logic [WIDTH:0] mul_sum, div_sh;
  logic           div_ge;
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, mc} : '0);
    div_sh  = {hi, lo[WIDTH-1]};
    div_ge  = div_sh >= {1'b0, mc};
    if (op_q[2]) begin
      // Restoring step: the difference always fits WIDTH bits when taken.
      hi_n = div_ge ? (div_sh[WIDTH-1:0] - mc) : div_sh[WIDTH-1:0];
      lo_n = {lo[WIDTH-2:0], div_ge};
    end else begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], lo[WIDTH-1:1]};
    end
  end

  logic [WIDTH-1:0] mdu_res;
  logic             mdu_v;
  always_comb begin
    mdu_v = (op_q == 4'd12) && (a_q == MIN_NEG) && (b_q == '1);
    case (op_q)
      4'd10: mdu_res = lo_n;
      4'd11: mdu_res = hi_n;
      // Divide by zero must read all-ones even when the signs differ.
      4'd12: mdu_res = (b_q == '0) ? '1 :
                       (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -lo_n : lo_n;
      4'd13: mdu_res = lo_n;
      4'd14: mdu_res = a_q[WIDTH-1] ? -hi_n : hi_n;
      default: mdu_res = hi_n;
    endcase
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = is_mdu ? BUSY : DONE;
      BUSY: if (last_step) state_nx = DONE;
      DONE: if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mc       <= '0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else if (accept) begin
      op_q <= bus.op;
      a_q  <= bus.A;
      b_q  <= bus.B;
      mc   <= mag_b;
      hi   <= '0;
      lo   <= mag_a;
      cnt  <= is_mdu ? CNT_W'(WIDTH) : '0;
      if (!is_mdu) begin
        result_q <= alu_res;
        carry_q  <= alu_c;
        ovf_q    <= alu_v;
        zero_q   <= ~|alu_res;
        neg_q    <= alu_res[WIDTH-1];
      end
    end else if (state == BUSY) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt - 1'b1;
      if (last_step) begin
        result_q <= mdu_res;
        carry_q  <= 1'b0;
        ovf_q    <= mdu_v;
        zero_q   <= ~|mdu_res;
        neg_q    <= mdu_res[WIDTH-1];
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.Result    = result_q;
  assign bus.Carry     = carry_q;
  assign bus.OverFlow  = ovf_q;
  assign bus.Zero      = zero_q;
  assign bus.Negative  = neg_q;
endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal: 8..64, even).
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH)+1, width of the iteration counter.
REQ-003 SHALL have port clk  input  1  single clock, all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 SHALL have port in_valid  input  1  request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port op  input  4  operation code.
REQ-008 SHALL have ports A, B  input  WIDTH  operands.
REQ-009 SHALL have port out_valid  output  1  Result and flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port Result  output  WIDTH  registered result.
REQ-012 SHALL have ports Carry, OverFlow, Zero, Negative  output  1 each  registered flags.

Function
REQ-013 Op codes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 MUL (low half), 11 MULHU (high half, unsigned), 12 DIV, 13 DIVU, 14 REM, 15 REMU.
REQ-014 Request SHALL be accepted on a rising edge where in_valid & in_ready; A, B, op captured then; later input changes ignored.
REQ-015 State machine SHALL have states IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-016 IDLE -> DONE on accept of ops 0-9 (latency 1: out_valid high after the accept edge).
REQ-017 IDLE -> BUSY on accept of ops 10-15; BUSY SHALL last exactly WIDTH cycles (one bit per cycle, shift-add multiply, restoring divide), then -> DONE; out_valid high WIDTH+1 edges after accept.
REQ-018 DONE SHALL hold Result/flags/out_valid stable until out_ready=1 on an edge, then -> IDLE; out_ready ignored outside DONE.
REQ-019 No new request SHALL be accepted in the same cycle the result is handed off (in_ready=0 in DONE).
REQ-020 Shifts SHALL use B[$clog2(WIDTH)-1:0] as amount; upper B bits ignored.
REQ-021 DIV/REM and MUL inputs SHALL be sign-handled via magnitude and sign correction for signed ops; DIVU/REMU/MULHU/MUL operate on unsigned magnitudes.
REQ-022 Divide by zero SHALL give quotient all-ones and remainder = A, with unchanged WIDTH-cycle latency.
REQ-023 Signed overflow (A = most negative, B = -1) SHALL give DIV = A, REM = 0, OverFlow = 1, same latency.
REQ-024 Carry SHALL be carry-out for ADD, borrow (A < B unsigned) for SUB, 0 otherwise.
REQ-025 OverFlow SHALL be signed overflow for ADD/SUB, per REQ-023 for DIV, 0 otherwise.
REQ-026 Zero SHALL be 1 iff Result == 0; Negative SHALL equal Result[WIDTH-1]; both for every op.
REQ-027 Flags SHALL be computed with the result and updated only on entry to DONE.

Reset
REQ-028 rst=0 SHALL immediately force state IDLE, Result=0, all flags 0, out_valid=0, counter=0; in_ready=1 after rst releases.
REQ-029 Reset during BUSY or DONE SHALL abort the operation with no result produced.
REQ-030 First accept SHALL be possible on the first rising edge with rst=1.

Verification
REQ-031 ADD A=0x7FFFFFFF, B=1 -> one cycle later Result=0x80000000, OverFlow=1, Negative=1, Carry=0.
REQ-032 SUB A=3, B=5 -> Result=0xFFFFFFFE, Carry=1, Negative=1; SLT A=0xFFFFFFFF, B=1 -> 1; SLTU same -> 0.
REQ-033 MUL A=0xFFFFFFFF, B=0xFFFFFFFF -> out_valid exactly 33 edges after accept, Result=1; MULHU same -> 0xFFFFFFFE.
REQ-034 DIV A=-7, B=2 -> Result=-3 (0xFFFFFFFD); REM -> -1; DIVU A=7, B=0 -> 0xFFFFFFFF; DIV A=0x80000000, B=-1 -> 0x80000000, OverFlow=1.
REQ-035 Hold out_ready=0 for 10 cycles in DONE with in_valid=1 -> Result stable, in_ready=0, no accept; out_ready=1 -> IDLE next edge.
REQ-036 Assert rst=0 mid-BUSY (cycle 12 of DIVU) -> out_valid=0, Result=0 immediately; new request after release completes correctly.
